pc_sequencer: RTL and testbench

Controls the program-counter register and the instruction-fetch handshake.
- Decides each cycle whether the PC loads and with which value: reset vector, trap vector, jump target, branch target or PC+4.
- Drives the instruction-memory request and reports each completed fetch to decode.
- Sits between the PC register (drives its load/in_data, reads its out_data), instruction memory, and the branch/jump/trap sources in execute.

---
 rtl/pc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencing and instruction-fetch handshake control.
// Each cycle it decides whether the external PC register loads, and with which
// value (reset vector, trap vector, jump target, branch target or PC+step).
// It drives the instruction-memory request and reports completed fetches.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   pc_cur         current PC (PC register out_data)
//   pc_load        load strobe to the PC register
//   pc_next        value presented to the PC register in_data
//   imem_req       fetch request to instruction memory
//   imem_addr      fetch address (always pc_cur)
//   imem_ready     instruction memory returns an instruction this cycle
//   fetch_valid    one-cycle pulse: instruction at pc_cur delivered
//   stall          downstream cannot accept the next instruction
//   branch_taken   conditional branch resolved taken (pulse)
//   branch_target  branch destination
//   jump           unconditional jump (pulse)
//   jump_target    jump destination
//   trap           exception/trap request (pulse)
//   trap_vector    trap handler address
//   misaligned     pulse: applied jump/branch target had addr[1:0] != 0
//   fetch_count    number of completed fetches (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned           XLEN         = 64,
    parameter logic [XLEN-1:0]       RESET_VECTOR = 64'h0,
    parameter int unsigned           PC_STEP      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            fetch_valid,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic            misaligned,
    output logic [XLEN-1:0] fetch_count
);

    // FSM state encodings
    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Redirect kinds, numerically ordered by priority so >= compares priority
    localparam logic [1:0] K_NONE   = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_JUMP   = 2'd2;
    localparam logic [1:0] K_TRAP   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [1:0]      pend_kind_q, pend_kind_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    logic [1:0]      cur_kind;
    logic [XLEN-1:0] cur_tgt;
    logic [1:0]      eff_kind;
    logic [XLEN-1:0] eff_tgt;
    logic            cur_wins;
    logic            misalign_hit;
    logic            advance;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redirect_pc;

    // Highest-priority redirect requested this cycle
    always_comb begin
        cur_kind = K_NONE;
        cur_tgt  = '0;
        if (trap) begin
            cur_kind = K_TRAP;
            cur_tgt  = trap_vector;
        end else if (jump) begin
            cur_kind = K_JUMP;
            cur_tgt  = jump_target;
        end else if (branch_taken) begin
            cur_kind = K_BRANCH;
            cur_tgt  = branch_target;
        end
    end

    // A current-cycle event of equal or higher priority supersedes the pending one
    assign cur_wins = (cur_kind != K_NONE) && (cur_kind >= pend_kind_q);

    always_comb begin
        eff_kind = pend_kind_q;
        eff_tgt  = pend_tgt_q;
        if (cur_wins) begin
            eff_kind = cur_kind;
            eff_tgt  = cur_tgt;
        end
    end

    // Only jump/branch targets are alignment-checked; trap vectors are trusted
    assign misalign_hit = ((eff_kind == K_JUMP) || (eff_kind == K_BRANCH)) &&
                          (eff_tgt[1:0] != 2'b00);

    assign seq_pc = pc_cur + XLEN'(PC_STEP);

    always_comb begin
        redirect_pc = seq_pc;
        if (eff_kind != K_NONE) begin
            redirect_pc = misalign_hit ? trap_vector : eff_tgt;
        end
    end

    assign advance = !reset &&
                     (((state_q == S_FETCH) && imem_ready && !stall) ||
                      ((state_q == S_HOLD) && !stall));

    assign imem_addr   = pc_cur;
    assign imem_req    = !reset && (state_q == S_FETCH);
    assign fetch_valid = !reset && (state_q == S_FETCH) && imem_ready;
    assign pc_load     = !reset && ((state_q == S_INIT) || advance);
    assign pc_next     = (state_q == S_INIT) ? RESET_VECTOR : redirect_pc;
    assign misaligned  = advance && misalign_hit;
    assign fetch_count = fetch_count_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = stall ? S_HOLD : S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Pending redirect: cleared on advance, otherwise latched if the new event wins
    always_comb begin
        pend_kind_d = pend_kind_q;
        pend_tgt_d  = pend_tgt_q;
        if (advance) begin
            pend_kind_d = K_NONE;
            pend_tgt_d  = '0;
        end else if (cur_wins) begin
            pend_kind_d = cur_kind;
            pend_tgt_d  = cur_tgt;
        end
    end

    assign fetch_count_d = fetch_count_q + XLEN'(fetch_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT;
            pend_kind_q   <= K_NONE;
            pend_tgt_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_kind_q   <= pend_kind_d;
            pend_tgt_q    <= pend_tgt_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer. Models the external PC register, drives
// inputs just after the falling edge and checks combinational outputs #1 later.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_cur;
    logic            pc_load;
    logic [XLEN-1:0] pc_next;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            fetch_valid;
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic            misaligned;
    logic [XLEN-1:0] fetch_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pc_sequencer #(
        .XLEN         (64),
        .RESET_VECTOR (64'h0),
        .PC_STEP      (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .fetch_valid   (fetch_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .trap_vector   (trap_vector),
        .misaligned    (misaligned),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // External PC register
    always @(posedge clk) begin
        if (pc_load) pc_cur <= pc_next;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        jump          = 1'b0;
        trap          = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        trap_vector   = 64'h100;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        clear_redirects();
        tick(); tick();
        #1;
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL reset_pc_load: got %b want 0", pc_load); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
        n_cmp++; if (fetch_count !== 64'h0) begin n_bad++; $display("FAIL reset_fetch_count: got %h want 0", fetch_count); end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        #1;
        n_cmp++; if (pc_load !== 1'b1) begin n_bad++; $display("FAIL init_pc_load: got %b want 1", pc_load); end
        n_cmp++; if (pc_next !== 64'h0) begin n_bad++; $display("FAIL init_pc_next: got %h want 0", pc_next); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL seq_imem_req[%0d]: got %b want 1", i, imem_req); end
            n_cmp++; if (imem_addr !== 64'(4 * i)) begin n_bad++; $display("FAIL seq_imem_addr[%0d]: got %h want %h", i, imem_addr, 64'(4 * i)); end
            n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL seq_fetch_valid[%0d]: got %b want 1", i, fetch_valid); end
            n_cmp++; if (pc_next !== 64'(4 * (i + 1))) begin n_bad++; $display("FAIL seq_pc_next[%0d]: got %h want %h", i, pc_next, 64'(4 * (i + 1))); end
            tick();
        end
        n_cmp++; if (fetch_count !== 64'd3) begin n_bad++; $display("FAIL seq_fetch_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_branch_pending();
        // 0xC -> 0x10 sequential
        #1;
        n_cmp++; if (pc_next !== 64'h10) begin n_bad++; $display("FAIL br_pre_pc_next: got %h want 10", pc_next); end
        tick();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h200;
        #1;
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL br_noready_pc_load: got %b want 0", pc_load); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL br_noready_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (imem_addr !== 64'h10) begin n_bad++; $display("FAIL br_noready_addr: got %h want 10", imem_addr); end
        tick();
        clear_redirects(); imem_ready = 1'b1;
        #1;
        n_cmp++; if (pc_load !== 1'b1) begin n_bad++; $display("FAIL br_ready_pc_load: got %b want 1", pc_load); end
        n_cmp++; if (pc_next !== 64'h200) begin n_bad++; $display("FAIL br_ready_pc_next: got %h want 200", pc_next); end
        tick();
        #1;
        n_cmp++; if (imem_addr !== 64'h200) begin n_bad++; $display("FAIL br_target_addr: got %h want 200", imem_addr); end
    endtask

    task automatic test_stall();
        jump = 1'b1; jump_target = 64'h40;
        #1;
        n_cmp++; if (pc_next !== 64'h40) begin n_bad++; $display("FAIL jmp_pc_next: got %h want 40", pc_next); end
        tick();
        clear_redirects(); stall = 1'b1;
        #1;
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL stall_fetch_valid: got %b want 1", fetch_valid); end
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL stall_fetch_pc_load: got %b want 0", pc_load); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_imem_req[%0d]: got %b want 0", i, imem_req); end
            n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL hold_pc_load[%0d]: got %b want 0", i, pc_load); end
            n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL hold_fetch_valid[%0d]: got %b want 0", i, fetch_valid); end
            tick();
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (pc_load !== 1'b1) begin n_bad++; $display("FAIL unstall_pc_load: got %b want 1", pc_load); end
        n_cmp++; if (pc_next !== 64'h44) begin n_bad++; $display("FAIL unstall_pc_next: got %h want 44", pc_next); end
        tick();
        #1;
        n_cmp++; if (imem_addr !== 64'h44) begin n_bad++; $display("FAIL unstall_addr: got %h want 44", imem_addr); end
    endtask

    task automatic test_simultaneous();
        trap = 1'b1; trap_vector = 64'h100;
        jump = 1'b1; jump_target = 64'h300;
        branch_taken = 1'b1; branch_target = 64'h500;
        #1;
        n_cmp++; if (pc_next !== 64'h100) begin n_bad++; $display("FAIL all3_pc_next: got %h want 100", pc_next); end
        n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL all3_misaligned: got %b want 0", misaligned); end
        tick();
        clear_redirects();
        #1;
        n_cmp++; if (pc_next !== 64'h104) begin n_bad++; $display("FAIL all3_after_pc_next: got %h want 104", pc_next); end
        tick();
    endtask

    task automatic test_misaligned();
        jump = 1'b1; jump_target = 64'h302; trap_vector = 64'h100;
        #1;
        n_cmp++; if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
        n_cmp++; if (pc_next !== 64'h100) begin n_bad++; $display("FAIL mis_pc_next: got %h want 100", pc_next); end
        tick();
        clear_redirects();
        #1;
        n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_single_pulse: got %b want 0", misaligned); end
        n_cmp++; if (pc_next !== 64'h104) begin n_bad++; $display("FAIL mis_after_pc_next: got %h want 104", pc_next); end
        tick();
    endtask

    task automatic test_pending_priority();
        imem_ready = 1'b0; jump = 1'b1; jump_target = 64'h600;
        #1;
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL pend_jmp_pc_load: got %b want 0", pc_load); end
        tick();
        clear_redirects(); branch_taken = 1'b1; branch_target = 64'h700;
        tick();
        clear_redirects(); imem_ready = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 64'h600) begin n_bad++; $display("FAIL pend_prio_pc_next: got %h want 600", pc_next); end
        tick();
        #1;
        n_cmp++; if (pc_next !== 64'h604) begin n_bad++; $display("FAIL pend_cleared_pc_next: got %h want 604", pc_next); end
        tick();
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        clear_redirects();
        #1;
        n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", imem_addr); end
        n_cmp++; if (pc_next !== 64'h0) begin n_bad++; $display("FAIL wrap_pc_next: got %h want 0", pc_next); end
        tick();
        // fetches so far: 3 + 0xC + 0x200 (branch applied) + 0x200 + 0x40 + 0x44 + 0x100 + 0x104
        //                 + 0x100 + 0x104 + 0x600 + top + wrap = 15
        n_cmp++; if (fetch_count !== 64'd15) begin n_bad++; $display("FAIL wrap_fetch_count: got %0d want 15", fetch_count); end
    endtask

    task automatic test_reset_midfetch();
        jump = 1'b1; jump_target = 64'h80;
        tick();
        clear_redirects();
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h80) begin n_bad++; $display("FAIL rstmid_pre: got req=%b addr=%h want req=1 addr=80", imem_req, imem_addr); end
        reset = 1'b1;
        #1;
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_fetch_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (pc_load !== 1'b0) begin n_bad++; $display("FAIL rstmid_pc_load: got %b want 0", pc_load); end
        tick();
        n_cmp++; if (fetch_count !== 64'h0) begin n_bad++; $display("FAIL rstmid_fetch_count: got %0d want 0", fetch_count); end
        reset = 1'b0;
        #1;
        n_cmp++; if (pc_load !== 1'b1) begin n_bad++; $display("FAIL rstmid_init_load: got %b want 1", pc_load); end
        n_cmp++; if (pc_next !== 64'h0) begin n_bad++; $display("FAIL rstmid_init_pc_next: got %h want 0", pc_next); end
        tick();
        #1;
        n_cmp++; if (imem_addr !== 64'h0 || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_refetch: got addr=%h fv=%b want addr=0 fv=1", imem_addr, fetch_valid); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
        clear_redirects();
        test_reset();
        test_sequential();
        test_branch_pending();
        test_stall();
        test_simultaneous();
        test_misaligned();
        test_pending_priority();
        test_wrap();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
